moving_sum_len_ctrl: RTL and testbench

//  Sequencer placed in front of and behind one moving_sum instance.

---
 rtl/moving_sum_len_ctrl_pkg.sv | 26 ++
 rtl/inflight_counter.sv | 29 ++
 rtl/moving_sum_len_ctrl.sv | 137 +++++++++++++
 tb/tb_moving_sum_len_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moving_sum_len_ctrl_pkg.sv
// Shared state encodings and helpers for the moving-sum length sequencer.
// Imported by the sequencer top and its in-flight counter.
package moving_sum_len_ctrl_pkg;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_FLUSH  = 2'd1;
   localparam logic [1:0] ST_CLEAR  = 2'd2;
   localparam logic [1:0] ST_WARMUP = 2'd3;

   localparam int SR_LEN_DEF = 8;

   // The whole 32-bit word is clamped, so oversize writes saturate to max.
   function automatic logic [31:0] clamp_len(
      input logic [31:0] d,
      input int unsigned lg2
   );
      logic [31:0] w_max;
      w_max = 32'd1 << lg2;
      if (d == 32'd0)
         return 32'd1;
      if (d > w_max)
         return w_max;
      return d;
   endfunction

endpackage

// File: rtl/inflight_counter.sv
// Up/down count of beats held inside moving_sum.
// Reports saturation and emptiness.
module inflight_counter #(
   parameter int W = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full,
   output logic o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (i_dec && !i_inc) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_full = &r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/moving_sum_len_ctrl.sv
// Wraps one moving_sum: applies length changes at packet boundaries,
// drains and clears it, then hides the partial-window warmup sums.
module moving_sum_len_ctrl
   import moving_sum_len_ctrl_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int MAX_LEN_LOG2 = 10,
   parameter int DEFAULT_LEN  = 1,
   parameter int SR_LEN       = SR_LEN_DEF,
   parameter int INFL_LOG2    = 4,
   localparam int OW = WIDTH + MAX_LEN_LOG2,
   localparam int LW = MAX_LEN_LOG2 + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [WIDTH-1:0] s_tdata,
   input  logic             s_tlast,
   input  logic             s_tvalid,
   output logic             s_tready,
   output logic [WIDTH-1:0] ms_i_tdata,
   output logic             ms_i_tlast,
   output logic             ms_i_tvalid,
   input  logic             ms_i_tready,
   output logic             ms_clear,
   output logic [LW-1:0]    ms_len,
   input  logic [OW-1:0]    ms_o_tdata,
   input  logic             ms_o_tlast,
   input  logic             ms_o_tvalid,
   output logic             ms_o_tready,
   output logic [OW-1:0]    m_tdata,
   output logic             m_tlast,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             busy
);

   logic [1:0]    r_state;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_pend_len;
   logic          r_pend;
   logic          r_in_pkt;
   logic [LW-1:0] r_warm;

   logic          w_wr;
   logic [LW-1:0] w_wr_len;
   logic [LW-1:0] w_next_len;
   logic          w_in_en;
   logic          w_out_pass;
   logic          w_inc;
   logic          w_dec;
   logic          w_full;
   logic          w_zero;

   assign w_wr       = set_stb && (set_addr == 8'(SR_LEN));
   assign w_wr_len   = LW'(clamp_len(set_data, MAX_LEN_LOG2));
   assign w_next_len = r_pend ? r_pend_len : r_len;

   // A pending length closes the input as soon as no packet is open.
   assign w_in_en = !w_full &&
      ((r_state == ST_RUN && !(r_pend && !r_in_pkt)) ||
       (r_state == ST_WARMUP));
   assign w_out_pass = (r_state == ST_RUN) || (r_state == ST_FLUSH);

   assign ms_i_tdata  = s_tdata;
   assign ms_i_tlast  = s_tlast;
   assign ms_i_tvalid = w_in_en && s_tvalid;
   assign s_tready    = w_in_en && ms_i_tready;

   assign m_tdata     = ms_o_tdata;
   assign m_tlast     = ms_o_tlast;
   assign m_tvalid    = w_out_pass && ms_o_tvalid;
   assign ms_o_tready = w_out_pass ? m_tready : (r_state == ST_WARMUP);

   assign ms_clear = (r_state == ST_CLEAR);
   assign ms_len   = r_len;
   assign busy     = (r_state != ST_RUN) || r_pend;

   assign w_inc = ms_i_tvalid && ms_i_tready;
   assign w_dec = ms_o_tvalid && ms_o_tready;

   inflight_counter #(
      .W (INFL_LOG2)
   ) u_infl (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .o_full  (w_full),
      .o_zero  (w_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_CLEAR;
         r_len      <= LW'(DEFAULT_LEN);
         r_pend_len <= LW'(1);
         r_pend     <= 1'b0;
         r_in_pkt   <= 1'b0;
         r_warm     <= '0;
      end else begin
         if (w_inc)
            r_in_pkt <= !s_tlast;
         case (r_state)
            ST_RUN: begin
               if (r_pend && !r_in_pkt)
                  r_state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (w_zero)
                  r_state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               r_len   <= w_next_len;
               r_warm  <= w_next_len - LW'(1);
               r_pend  <= 1'b0;
               r_state <= (w_next_len > LW'(1)) ? ST_WARMUP : ST_RUN;
            end
            ST_WARMUP: begin
               if (w_dec) begin
                  r_warm <= r_warm - LW'(1);
                  if (r_warm == LW'(1))
                     r_state <= ST_RUN;
               end
            end
         endcase
         // A write in the clear cycle must survive the pend reset above.
         if (w_wr) begin
            r_pend     <= 1'b1;
            r_pend_len <= w_wr_len;
         end
      end
   end

endmodule

// File: tb/tb_moving_sum_len_ctrl.sv
// Directed bench for moving_sum_len_ctrl with a behavioural moving_sum
// (one output register) closing the loop between the two ms_* ports.
module tb_moving_sum_len_ctrl;

   localparam int WIDTH = 16;
   localparam int MLL   = 10;
   localparam int OW    = WIDTH + MLL;
   localparam int LW    = MLL + 1;

   logic             clk;
   logic             reset_n;
   logic             set_stb;
   logic [7:0]       set_addr;
   logic [31:0]      set_data;
   logic [WIDTH-1:0] s_tdata;
   logic             s_tlast;
   logic             s_tvalid;
   logic             s_tready;
   logic [WIDTH-1:0] ms_i_tdata;
   logic             ms_i_tlast;
   logic             ms_i_tvalid;
   logic             ms_i_tready;
   logic             ms_clear;
   logic [LW-1:0]    ms_len;
   logic [OW-1:0]    ms_o_tdata;
   logic             ms_o_tlast;
   logic             ms_o_tvalid;
   logic             ms_o_tready;
   logic [OW-1:0]    m_tdata;
   logic             m_tlast;
   logic             m_tvalid;
   logic             m_tready;
   logic             busy;

   moving_sum_len_ctrl #(
      .WIDTH        (WIDTH),
      .MAX_LEN_LOG2 (MLL),
      .DEFAULT_LEN  (20),
      .SR_LEN       (8),
      .INFL_LOG2    (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .set_stb     (set_stb),
      .set_addr    (set_addr),
      .set_data    (set_data),
      .s_tdata     (s_tdata),
      .s_tlast     (s_tlast),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .ms_i_tdata  (ms_i_tdata),
      .ms_i_tlast  (ms_i_tlast),
      .ms_i_tvalid (ms_i_tvalid),
      .ms_i_tready (ms_i_tready),
      .ms_clear    (ms_clear),
      .ms_len      (ms_len),
      .ms_o_tdata  (ms_o_tdata),
      .ms_o_tlast  (ms_o_tlast),
      .ms_o_tvalid (ms_o_tvalid),
      .ms_o_tready (ms_o_tready),
      .m_tdata     (m_tdata),
      .m_tlast     (m_tlast),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural moving_sum
   logic [WIDTH-1:0] hist [0:2047];
   int               mn;
   logic [OW-1:0]    macc;
   logic [OW-1:0]    w_sub;
   logic [OW-1:0]    w_nacc;
   logic             mo_valid;
   logic             mo_last;
   logic [OW-1:0]    mo_data;

   assign ms_i_tready = !mo_valid || ms_o_tready;
   assign ms_o_tvalid = mo_valid;
   assign ms_o_tdata  = mo_data;
   assign ms_o_tlast  = mo_last;

   always_comb begin
      w_sub = '0;
      if (mn >= int'(ms_len))
         w_sub = OW'(hist[(mn - int'(ms_len)) % 2048]);
      w_nacc = macc + OW'(ms_i_tdata) - w_sub;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mo_valid <= 1'b0;
         mn       <= 0;
         macc     <= '0;
      end else if (ms_clear) begin
         mo_valid <= 1'b0;
         mn       <= 0;
         macc     <= '0;
      end else begin
         if (ms_o_tvalid && ms_o_tready)
            mo_valid <= 1'b0;
         if (ms_i_tvalid && ms_i_tready) begin
            hist[mn % 2048] <= ms_i_tdata;
            macc     <= w_nacc;
            mn       <= mn + 1;
            mo_valid <= 1'b1;
            mo_data  <= w_nacc;
            mo_last  <= ms_i_tlast;
         end
      end
   end

   // Output collector and clear monitor
   logic [OW:0] q [$];
   int          clr_cnt = 0;
   int          viol = 0;

   always @(posedge clk) begin
      if (reset_n) begin
         if (m_tvalid && m_tready)
            q.push_back({m_tlast, m_tdata});
         if (ms_clear) begin
            clr_cnt <= clr_cnt + 1;
            if (mo_valid)
               viol <= viol + 1;
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit thr = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      m_tready = thr ? (cyc % 4 == 0) : 1'b1;
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         tick();
   endtask

   task automatic write_len(input logic [31:0] v);
      tick();
      set_stb  = 1'b1;
      set_data = v;
      tick();
      set_stb  = 1'b0;
   endtask

   task automatic send(input int n, input int wa, input logic [31:0] wv,
                       input int wb, input logic [31:0] wv2,
                       output int stalls);
      int   i;
      int   budget;
      bit   da;
      bit   db;
      logic rdy;
      i = 0;
      budget = 0;
      da = 1'b0;
      db = 1'b0;
      stalls = 0;
      while (i < n && budget < 5000) begin
         tick();
         set_stb = 1'b0;
         if (i == wa && !da) begin
            set_stb  = 1'b1;
            set_data = wv;
            da = 1'b1;
         end else if (i == wb && !db) begin
            set_stb  = 1'b1;
            set_data = wv2;
            db = 1'b1;
         end
         s_tvalid = 1'b1;
         s_tdata  = 16'd1;
         s_tlast  = (i == n - 1);
         rdy = s_tready;
         if (!rdy && i > 0)
            stalls++;
         @(posedge clk);
         if (rdy)
            i++;
         budget++;
      end
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      set_stb  = 1'b0;
      if (i < n)
         chk("send_timeout", 64'(i), 64'(n));
   endtask

   task automatic check_q(input string tag, input int cnt,
                          input logic [OW-1:0] val);
      int bad;
      bad = 0;
      chk({tag, "_cnt"}, 64'(q.size()), 64'(cnt));
      foreach (q[k])
         if (q[k][OW-1:0] !== val)
            bad++;
      chk({tag, "_val"}, 64'(bad), 64'd0);
      if (q.size() > 0)
         chk({tag, "_last"}, 64'(q[q.size() - 1][OW]), 64'd1);
      q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int c0;
      reset_n  = 1'b0;
      set_stb  = 1'b0;
      set_addr = 8'd8;
      set_data = '0;
      s_tdata  = 16'd1;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      m_tready = 1'b1;
      idle(2);

      // Reset values, with upstream offering data
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_ms_i_tvalid", 64'(ms_i_tvalid), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_ms_o_tready", 64'(ms_o_tready), 64'd0);
      chk("rst_ms_clear", 64'(ms_clear), 64'd1);
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_ms_len", 64'(ms_len), 64'd20);
      s_tvalid = 1'b0;
      reset_n  = 1'b1;
      tick();
      chk("t1_clr_once", 64'(clr_cnt), 64'd1);
      chk("t1_clr_low", 64'(ms_clear), 64'd0);
      chk("t1_busy_warm", 64'(busy), 64'd1);

      // 1: default length 20 warms up over 19 dropped sums
      send(40, -1, 0, -1, 0, st);
      idle(4);
      check_q("t1", 21, 26'd20);
      chk("t1_stall", 64'(st), 64'd0);

      // 2: length write mid-packet waits for the packet end
      send(32, 10, 32'd5, -1, 0, st);
      chk("t2_stall", 64'(st), 64'd0);
      chk("t2_gate", 64'(s_tready), 64'd0);
      chk("t2_noclr", 64'(clr_cnt), 64'd1);
      idle(6);
      chk("t2_clr", 64'(clr_cnt), 64'd2);
      chk("t2_len", 64'(ms_len), 64'd5);
      check_q("t2a", 32, 26'd20);
      send(20, -1, 0, -1, 0, st);
      idle(4);
      check_q("t2b", 16, 26'd5);

      // 3: last of two pending writes wins, one clear
      send(12, 3, 32'd7, 6, 32'd3, st);
      idle(6);
      chk("t3_clr", 64'(clr_cnt), 64'd3);
      chk("t3_len", 64'(ms_len), 64'd3);
      check_q("t3a", 12, 26'd5);
      send(10, -1, 0, -1, 0, st);
      idle(4);
      check_q("t3b", 8, 26'd3);

      // 4: clamp low and high
      write_len(32'd0);
      idle(6);
      chk("t4_clr0", 64'(clr_cnt), 64'd4);
      chk("t4_len0", 64'(ms_len), 64'd1);
      chk("t4_busy0", 64'(busy), 64'd0);
      send(6, -1, 0, -1, 0, st);
      idle(4);
      check_q("t4a", 6, 26'd1);
      write_len(32'd5000);
      idle(6);
      chk("t4_len_max", 64'(ms_len), 64'd1024);
      chk("t4_busy_warm", 64'(busy), 64'd1);
      send(1030, -1, 0, -1, 0, st);
      idle(4);
      check_q("t4b", 7, 26'd1024);
      chk("t4_clr_max", 64'(clr_cnt), 64'd5);

      // 5: throttled downstream across flush
      thr = 1'b1;
      send(8, 4, 32'd2, -1, 0, st);
      idle(40);
      chk("t5_viol", 64'(viol), 64'd0);
      chk("t5_clr", 64'(clr_cnt), 64'd6);
      check_q("t5a", 8, 26'd1024);
      thr = 1'b0;
      send(6, -1, 0, -1, 0, st);
      idle(4);
      check_q("t5b", 5, 26'd2);

      // 6: reset during warmup
      c0 = clr_cnt;
      write_len(32'd50);
      idle(6);
      chk("t6_len", 64'(ms_len), 64'd50);
      send(10, -1, 0, -1, 0, st);
      idle(3);
      check_q("t6a", 0, 26'd0);
      chk("t6_busy", 64'(busy), 64'd1);
      tick();
      s_tvalid = 1'b1;
      reset_n  = 1'b0;
      #1;
      chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
      chk("t6_rst_ms_i_tvalid", 64'(ms_i_tvalid), 64'd0);
      chk("t6_rst_ms_o_tready", 64'(ms_o_tready), 64'd0);
      chk("t6_rst_ms_clear", 64'(ms_clear), 64'd1);
      chk("t6_rst_ms_len", 64'(ms_len), 64'd20);
      idle(2);
      s_tvalid = 1'b0;
      reset_n  = 1'b1;
      tick();
      chk("t6_clr", 64'(clr_cnt - c0), 64'd2);
      send(25, -1, 0, -1, 0, st);
      idle(4);
      check_q("t6b", 6, 26'd20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
